// File: rtl/kyber_pkg.sv
// Shared constants and FSM state type for the Kyber polynomial add/reduce datapath.
package kyber_pkg;

    localparam int KYBER_N         = 256;
    localparam int KYBER_Q         = 3329;
    localparam int COEF_W          = 12;
    localparam int SPOLY_W_DEFAULT = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN_U = 2'd1,
        RUN_V = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/modq_add3.sv
// One-lane mod-q adder: r = (a + (enable_b ? b : 0) + e) mod q, for a, b in [0,q) and small signed e.
module modq_add3
    import kyber_pkg::*;
#(
    parameter int SPOLY_W = SPOLY_W_DEFAULT
) (
    input  logic [COEF_W-1:0]         a,
    input  logic [COEF_W-1:0]         b,
    input  logic signed [SPOLY_W-1:0] e,
    input  logic                      enable_b,
    output logic [COEF_W-1:0]         r
);
    localparam int SUM_W = 14;
    localparam logic signed [SUM_W-1:0] Q_S = SUM_W'(KYBER_Q);

    logic signed [SUM_W-1:0] a_ext, b_ext, e_ext, s0, s1, s2;

    // Three-operand sums reach 2q-2 plus noise, so up to two subtractions may be needed.
    always_comb begin
        a_ext = {2'b00, a};
        b_ext = enable_b ? {2'b00, b} : '0;
        e_ext = {{(SUM_W - SPOLY_W){e[SPOLY_W-1]}}, e};
        s0    = a_ext + b_ext + e_ext;
        s1    = (s0 >= Q_S) ? s0 - Q_S : s0;
        s2    = (s1 >= Q_S) ? s1 - Q_S : s1;
        r     = s2[SUM_W-1] ? COEF_W'(s2 + Q_S) : COEF_W'(s2);
    end

endmodule

// File: rtl/poly_add_modq.sv
// Adds noise (and the message, for v) to the A^T*r and t^T*r polynomials mod q,
// LANES coefficients per cycle: every u[] polynomial first, then v.
//
// state | meaning
// IDLE  | waiting for start, results held
// RUN_U | writing u[poly] group idx
// RUN_V | writing v group idx
// DONE  | one-cycle valid pulse
module poly_add_modq
    import kyber_pkg::*;
#(
    parameter int K       = 3,
    parameter int LANES   = 64,
    parameter int SPOLY_W = SPOLY_W_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [KYBER_N*COEF_W-1:0]  x [K],
    input  logic [KYBER_N*COEF_W-1:0]  y,
    input  logic [KYBER_N*COEF_W-1:0]  msg_poly,
    input  logic [KYBER_N*SPOLY_W-1:0] e_1 [K],
    input  logic [KYBER_N*SPOLY_W-1:0] e_2,
    output logic [KYBER_N*COEF_W-1:0]  u [K],
    output logic [KYBER_N*COEF_W-1:0]  v,
    output logic                       busy,
    output logic                       valid
);
    localparam int G      = KYBER_N / LANES;
    localparam int IDX_W  = (G > 1) ? $clog2(G) : 1;
    localparam int POLY_W = (K > 1) ? $clog2(K) : 1;
    localparam int GRP_W  = LANES * COEF_W;
    localparam int GRP_EW = LANES * SPOLY_W;

    state_t                     state, state_nx;
    logic [IDX_W-1:0]           idx;
    logic [POLY_W-1:0]          poly;
    logic                       idx_last, poly_last, run_v;
    logic [KYBER_N*COEF_W-1:0]  a_poly;
    logic [KYBER_N*SPOLY_W-1:0] e_poly;
    logic [GRP_W-1:0]           a_grp, b_grp, r_grp;
    logic [GRP_EW-1:0]          e_grp;

    assign idx_last  = (idx == IDX_W'(G - 1));
    assign poly_last = (poly == POLY_W'(K - 1));
    assign run_v     = (state == RUN_V);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN_U;
            RUN_U:   if (idx_last && poly_last) state_nx = RUN_V;
            RUN_V:   if (idx_last) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy  = (state != IDLE);
        valid = (state == DONE);
    end

    // Only one group of operands is routed to the lane adders each cycle.
    assign a_poly = run_v ? y : x[poly];
    assign e_poly = run_v ? e_2 : e_1[poly];
    assign a_grp  = a_poly[idx*GRP_W +: GRP_W];
    assign b_grp  = msg_poly[idx*GRP_W +: GRP_W];
    assign e_grp  = e_poly[idx*GRP_EW +: GRP_EW];

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        modq_add3 #(.SPOLY_W(SPOLY_W)) u_add (
            .a        (a_grp[l*COEF_W +: COEF_W]),
            .b        (b_grp[l*COEF_W +: COEF_W]),
            .e        (e_grp[l*SPOLY_W +: SPOLY_W]),
            .enable_b (run_v),
            .r        (r_grp[l*COEF_W +: COEF_W])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx  <= '0;
            poly <= '0;
            v    <= '0;
            for (int i = 0; i < K; i++) u[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        idx  <= '0;
                        poly <= '0;
                    end
                end
                RUN_U: begin
                    for (int i = 0; i < K; i++)
                        if (poly == POLY_W'(i)) u[i][idx*GRP_W +: GRP_W] <= r_grp;
                    if (idx_last) begin
                        idx  <= '0;
                        poly <= poly_last ? '0 : poly + 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                RUN_V: begin
                    v[idx*GRP_W +: GRP_W] <= r_grp;
                    idx <= idx_last ? '0 : idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_poly_add_modq.sv
// Directed bench for poly_add_modq across three parameter sets, with an integer mod-q model.
`timescale 1ns/1ps
module tb_poly_add_modq;
    localparam int N  = 256;
    localparam int Q  = 3329;
    localparam int PW = N * 12;
    localparam int EW = N * 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic          start3, busy3, valid3;
    logic [PW-1:0] x3 [3];
    logic [PW-1:0] u3 [3];
    logic [EW-1:0] e1_3 [3];
    logic [PW-1:0] y3, m3, v3;
    logic [EW-1:0] e2_3;

    logic          start2, busy2, valid2;
    logic [PW-1:0] x2 [2];
    logic [PW-1:0] u2 [2];
    logic [EW-1:0] e1_2 [2];
    logic [PW-1:0] y2, m2, v2;
    logic [EW-1:0] e2_2;
    logic [PW-1:0] eu2 [2];
    logic [PW-1:0] ev2;

    logic          start4, busy4, valid4;
    logic [PW-1:0] x4 [4];
    logic [PW-1:0] u4 [4];
    logic [EW-1:0] e1_4 [4];
    logic [PW-1:0] y4, m4, v4;
    logic [EW-1:0] e2_4;
    logic [PW-1:0] eu4 [4];
    logic [PW-1:0] ev4;

    poly_add_modq #(.K(3), .LANES(256), .SPOLY_W(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .x(x3), .y(y3), .msg_poly(m3),
        .e_1(e1_3), .e_2(e2_3), .u(u3), .v(v3), .busy(busy3), .valid(valid3));

    poly_add_modq #(.K(2), .LANES(64), .SPOLY_W(3)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .x(x2), .y(y2), .msg_poly(m2),
        .e_1(e1_2), .e_2(e2_2), .u(u2), .v(v2), .busy(busy2), .valid(valid2));

    poly_add_modq #(.K(4), .LANES(32), .SPOLY_W(3)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .x(x4), .y(y4), .msg_poly(m4),
        .e_1(e1_4), .e_2(e2_4), .u(u4), .v(v4), .busy(busy4), .valid(valid4));

    function automatic int modq(input int s);
        return ((s % Q) + Q) % Q;
    endfunction

    function automatic int coef(input logic [PW-1:0] p, input int j);
        return int'(p[12*j +: 12]);
    endfunction

    function automatic int noise(input logic [EW-1:0] p, input int j);
        logic signed [2:0] s;
        s = p[3*j +: 3];
        return int'(s);
    endfunction

    function automatic logic [PW-1:0] fill_c(input int val);
        logic [PW-1:0] p;
        for (int j = 0; j < N; j++) p[12*j +: 12] = 12'(val);
        return p;
    endfunction

    function automatic logic [EW-1:0] fill_e(input int val);
        logic [EW-1:0] p;
        for (int j = 0; j < N; j++) p[3*j +: 3] = 3'(val);
        return p;
    endfunction

    // Coefficients 0 and 1 pinned to the range extremes so every random run hits both corrections.
    function automatic logic [PW-1:0] rand_c();
        logic [PW-1:0] p;
        for (int j = 0; j < N; j++) p[12*j +: 12] = 12'($urandom_range(0, Q - 1));
        p[11:0]  = 12'd3328;
        p[23:12] = 12'd0;
        return p;
    endfunction

    function automatic logic [EW-1:0] rand_e();
        logic [EW-1:0] p;
        for (int j = 0; j < N; j++) p[3*j +: 3] = 3'($urandom_range(0, 7));
        p[2:0] = 3'b011;
        p[5:3] = 3'b100;
        return p;
    endfunction

    function automatic logic [PW-1:0] model(input logic [PW-1:0] a, input logic [PW-1:0] b,
                                            input logic [EW-1:0] e);
        logic [PW-1:0] p;
        for (int j = 0; j < N; j++) p[12*j +: 12] = 12'(modq(coef(a, j) + coef(b, j) + noise(e, j)));
        return p;
    endfunction

    function automatic int first_diff(input logic [PW-1:0] got, input logic [PW-1:0] exp);
        for (int j = 0; j < N; j++) if (got[12*j +: 12] !== exp[12*j +: 12]) return j;
        return 0;
    endfunction

    task automatic load_k2_random();
        for (int i = 0; i < 2; i++) begin
            x2[i]   = rand_c();
            e1_2[i] = rand_e();
            eu2[i]  = model(x2[i], '0, e1_2[i]);
        end
        y2   = rand_c();
        m2   = rand_c();
        e2_2 = rand_e();
        ev2  = model(y2, m2, e2_2);
    endtask

    task automatic load_k4_random();
        for (int i = 0; i < 4; i++) begin
            x4[i]   = rand_c();
            e1_4[i] = rand_e();
            eu4[i]  = model(x4[i], '0, e1_4[i]);
        end
        y4   = rand_c();
        m4   = rand_c();
        e2_4 = rand_e();
        ev4  = model(y4, m4, e2_4);
    endtask

    task automatic test_reset();
        start3 = 1'b0; start2 = 1'b0; start4 = 1'b0;
        for (int i = 0; i < 3; i++) begin x3[i] = '0; e1_3[i] = '0; end
        y3 = '0; m3 = '0; e2_3 = '0;
        load_k2_random();
        load_k4_random();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({busy3, valid3, busy2, valid2, busy4, valid4} !== 6'b0) begin
            bad++;
            $display("FAIL rst_ctrl got %b exp 000000", {busy3, valid3, busy2, valid2, busy4, valid4});
        end
        total++;
        if ((v3 | v2 | v4) !== '0) begin
            bad++;
            $display("FAIL rst_v got nonzero exp 0");
        end
        total++;
        if ((u3[0] | u3[1] | u3[2] | u2[0] | u2[1] | u4[0] | u4[1] | u4[2] | u4[3]) !== '0) begin
            bad++;
            $display("FAIL rst_u got nonzero exp 0");
        end
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if ({busy3, busy2, busy4} !== 3'b0 || (v2 | u2[0]) !== '0) begin
            bad++;
            $display("FAIL rst_release busy got %b exp 000 or u/v changed", {busy3, busy2, busy4});
        end
    endtask

    task automatic test_k3_directed();
        int tx[3]  = '{3328, 0, 3328};
        int te1[3] = '{1, -2, -4};
        int tyv[3] = '{0, 3328, 0};
        int te2[3] = '{-1, 2, -2};
        int eu[3]  = '{0, 3327, 3324};
        int ev[3]  = '{3328, 0, 3327};
        int lat, j;
        for (int s = 0; s < 3; s++) begin
            for (int i = 0; i < 3; i++) begin
                x3[i]   = fill_c(tx[s]);
                e1_3[i] = fill_e(te1[s]);
            end
            y3 = fill_c(tyv[s]); m3 = fill_c(tyv[s]); e2_3 = fill_e(te2[s]);
            @(negedge clk); start3 = 1'b1;
            @(negedge clk); start3 = 1'b0;
            lat = 1;
            while (valid3 !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
            total++;
            if (lat !== 5) begin
                bad++;
                $display("FAIL k3_latency s%0d got %0d exp 5", s, lat);
            end
            for (int i = 0; i < 3; i++) begin
                total++;
                if (u3[i] !== fill_c(eu[s])) begin
                    bad++;
                    j = first_diff(u3[i], fill_c(eu[s]));
                    $display("FAIL k3_u%0d s%0d coef %0d got %0d exp %0d", i, s, j, coef(u3[i], j), eu[s]);
                end
            end
            total++;
            if (v3 !== fill_c(ev[s])) begin
                bad++;
                j = first_diff(v3, fill_c(ev[s]));
                $display("FAIL k3_v s%0d coef %0d got %0d exp %0d", s, j, coef(v3, j), ev[s]);
            end
            repeat (3) @(negedge clk);
            total++;
            if (valid3 !== 1'b0 || busy3 !== 1'b0 || v3 !== fill_c(ev[s])) begin
                bad++;
                $display("FAIL k3_hold s%0d valid %b busy %b exp 0 0 with v held", s, valid3, busy3);
            end
        end
    endtask

    task automatic test_k2_random();
        int fv = 0, nv = 0, nb = 0, j;
        load_k2_random();
        @(negedge clk); start2 = 1'b1;
        @(negedge clk); start2 = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (valid2 === 1'b1) begin nv++; if (fv == 0) fv = c; end
            if (busy2 !== (c <= 13)) nb++;
            @(negedge clk);
        end
        total++;
        if (fv !== 13) begin bad++; $display("FAIL k2_valid_cycle got %0d exp 13", fv); end
        total++;
        if (nv !== 1) begin bad++; $display("FAIL k2_valid_count got %0d exp 1", nv); end
        total++;
        if (nb !== 0) begin bad++; $display("FAIL k2_busy_window got %0d wrong cycles exp 0", nb); end
        for (int i = 0; i < 2; i++) begin
            total++;
            if (u2[i] !== eu2[i]) begin
                bad++;
                j = first_diff(u2[i], eu2[i]);
                $display("FAIL k2_u%0d coef %0d got %0d exp %0d", i, j, coef(u2[i], j), coef(eu2[i], j));
            end
        end
        total++;
        if (v2 !== ev2) begin
            bad++;
            j = first_diff(v2, ev2);
            $display("FAIL k2_v coef %0d got %0d exp %0d", j, coef(v2, j), coef(ev2, j));
        end
    endtask

    // start re-pulsed mid-run and again during DONE; neither may launch a second run.
    task automatic test_restart_ignored();
        int fv = 0, nv = 0, nb = 0, j;
        load_k2_random();
        @(negedge clk); start2 = 1'b1;
        @(negedge clk); start2 = 1'b0;
        for (int c = 1; c <= 24; c++) begin
            if (valid2 === 1'b1) begin nv++; if (fv == 0) fv = c; end
            if (busy2 !== (c <= 13)) nb++;
            start2 = (c == 3) || (valid2 === 1'b1);
            @(negedge clk);
        end
        start2 = 1'b0;
        total++;
        if (fv !== 13 || nv !== 1) begin
            bad++;
            $display("FAIL restart_valid got first %0d count %0d exp 13 1", fv, nv);
        end
        total++;
        if (nb !== 0) begin bad++; $display("FAIL restart_busy got %0d wrong cycles exp 0", nb); end
        total++;
        if (u2[0] !== eu2[0] || u2[1] !== eu2[1]) begin
            bad++;
            j = first_diff(u2[0], eu2[0]);
            $display("FAIL restart_u coef %0d got %0d exp %0d", j, coef(u2[0], j), coef(eu2[0], j));
        end
        total++;
        if (v2 !== ev2) begin
            bad++;
            j = first_diff(v2, ev2);
            $display("FAIL restart_v coef %0d got %0d exp %0d", j, coef(v2, j), coef(ev2, j));
        end
    endtask

    task automatic test_back_to_back();
        int lat, j;
        logic [PW-1:0] a_u0, a_u1;
        load_k2_random();
        a_u0 = eu2[0];
        a_u1 = eu2[1];
        @(negedge clk); start2 = 1'b1;
        @(negedge clk); start2 = 1'b0;
        lat = 1;
        while (valid2 !== 1'b1 && lat < 30) begin @(negedge clk); lat++; end
        total++;
        if (lat !== 13 || u2[0] !== a_u0) begin
            bad++;
            $display("FAIL b2b_first latency got %0d exp 13 or u0 wrong", lat);
        end
        @(negedge clk);
        load_k2_random();
        start2 = 1'b1;
        @(negedge clk); start2 = 1'b0;
        total++;
        if (u2[1] !== a_u1) begin
            bad++;
            j = first_diff(u2[1], a_u1);
            $display("FAIL b2b_hold coef %0d got %0d exp %0d", j, coef(u2[1], j), coef(a_u1, j));
        end
        lat = 1;
        while (valid2 !== 1'b1 && lat < 30) begin @(negedge clk); lat++; end
        total++;
        if (lat !== 13) begin bad++; $display("FAIL b2b_latency got %0d exp 13", lat); end
        total++;
        if (u2[0] !== eu2[0] || u2[1] !== eu2[1] || v2 !== ev2) begin
            bad++;
            j = first_diff(v2, ev2);
            $display("FAIL b2b_second v coef %0d got %0d exp %0d (or u mismatch)", j, coef(v2, j), coef(ev2, j));
        end
    endtask

    task automatic test_reset_abort();
        int lat, nv = 0, j;
        load_k4_random();
        @(negedge clk); start4 = 1'b1;
        @(negedge clk); start4 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if (busy4 !== 1'b0 || valid4 !== 1'b0) begin
            bad++;
            $display("FAIL abort_ctrl got busy %b valid %b exp 0 0", busy4, valid4);
        end
        total++;
        if ((u4[0] | u4[1] | u4[2] | u4[3] | v4) !== '0) begin
            bad++;
            $display("FAIL abort_data got nonzero exp 0");
        end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 50; c++) begin
            if (valid4 === 1'b1 || busy4 === 1'b1) nv++;
            @(negedge clk);
        end
        total++;
        if (nv !== 0) begin bad++; $display("FAIL abort_quiet got %0d active cycles exp 0", nv); end
        @(negedge clk); start4 = 1'b1;
        @(negedge clk); start4 = 1'b0;
        lat = 1;
        while (valid4 !== 1'b1 && lat < 80) begin @(negedge clk); lat++; end
        total++;
        if (lat !== 41) begin bad++; $display("FAIL abort_restart_latency got %0d exp 41", lat); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (u4[i] !== eu4[i]) begin
                bad++;
                j = first_diff(u4[i], eu4[i]);
                $display("FAIL abort_u%0d coef %0d got %0d exp %0d", i, j, coef(u4[i], j), coef(eu4[i], j));
            end
        end
        total++;
        if (v4 !== ev4) begin
            bad++;
            j = first_diff(v4, ev4);
            $display("FAIL abort_v coef %0d got %0d exp %0d", j, coef(v4, j), coef(ev4, j));
        end
    endtask

    initial begin
        test_reset();
        test_k3_directed();
        test_k2_random();
        test_restart_ignored();
        test_back_to_back();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
